apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin arbiter driving one APB master port
//
// Purpose:
//    Serves two level-held transfer requests onto a single APB slave port.
//    A round-robin pointer picks the winner when both requesters are waiting.
//    Each transfer runs SETUP and then ACCESS. It completes either on pready
//    or when TIMEOUT ACCESS cycles pass without pready. Completion returns
//    to IDLE with a one-cycle done pulse to the served requester.
//    Every output comes straight from a register.
//
// Ports:
//    clk            rising-edge clock
//    resetn         asynchronous active-low reset
//    req_i[1:0]     per-requester request, held until that requester's done
//    req_write_i    per-requester direction (1 = write)
//    req_addr0_i    requester 0 word address
//    req_addr1_i    requester 1 word address
//    req_wdata0_i   requester 0 write data
//    req_wdata1_i   requester 1 write data
//    done_o[1:0]    one-cycle completion pulse to the served requester
//    rsp_rdata_o    read data, valid with done_o
//    rsp_err_o      error flag (slave error or timeout), valid with done_o
//    psel_o         APB select
//    penable_o      APB enable
//    pwrite_o       APB direction
//    paddr_o        APB address
//    pwdata_o       APB write data
//    pready_i       APB slave ready
//    pslverr_i      APB slave error
//    prdata_i       APB slave read data

module apb_req_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  req_i,
   input  logic [1:0]  req_write_i,
   input  logic [4:0]  req_addr0_i,
   input  logic [4:0]  req_addr1_i,
   input  logic [31:0] req_wdata0_i,
   input  logic [31:0] req_wdata1_i,
   output logic [1:0]  done_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [4:0]  paddr_o,
   output logic [31:0] pwdata_o,
   input  logic        pready_i,
   input  logic        pslverr_i,
   input  logic [31:0] prdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Last wait cycle: the counter holds the number of ACCESS cycles already
   // spent, so it equals TIMEOUT-1 during the TIMEOUT-th ACCESS cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        grant_q, grant_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [4:0]  paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [1:0]  done_q, done_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [1:0]  req_m;
   logic        win;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      tcnt_d      = tcnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      done_d      = 2'b00;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;

      // A requester whose done is showing this cycle has not yet seen it,
      // so its still-high req must not start a second transfer.
      req_m = req_i & ~done_q;
      win   = req_m[ptr_q] ? ptr_q : ~ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (|req_m) begin
               grant_d   = win;
               pwrite_d  = req_write_i[win];
               paddr_d   = win ? req_addr1_i : req_addr0_i;
               pwdata_d  = req_write_i[win] ? (win ? req_wdata1_i : req_wdata0_i) : 32'h0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            tcnt_d    = 8'h00;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
            if (pready_i || (tcnt_q == TO_LAST)) begin
               state_d   = ST_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = grant_q ? 2'b10 : 2'b01;
               ptr_d     = ~grant_q;
               if (pready_i) begin
                  rsp_err_d   = pslverr_i;
                  rsp_rdata_d = pwrite_q ? 32'h0 : prdata_i;
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end
            end else begin
               tcnt_d = tcnt_q + 8'h01;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b0;
         grant_q     <= 1'b0;
         tcnt_q      <= 8'h00;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 5'h00;
         pwdata_q    <= 32'h0;
         done_q      <= 2'b00;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         tcnt_q      <= tcnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         done_q      <= done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign done_o      = done_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter

module tb_apb_req_arbiter;

   logic        clk;
   logic        resetn;
   logic [1:0]  req_i;
   logic [1:0]  req_write_i;
   logic [4:0]  req_addr0_i, req_addr1_i;
   logic [31:0] req_wdata0_i, req_wdata1_i;
   logic [1:0]  done_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        psel_o, penable_o, pwrite_o;
   logic [4:0]  paddr_o;
   logic [31:0] pwdata_o;
   logic        pready_i, pslverr_i;
   logic [31:0] prdata_i;

   apb_req_arbiter #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_i        (req_i),
      .req_write_i  (req_write_i),
      .req_addr0_i  (req_addr0_i),
      .req_addr1_i  (req_addr1_i),
      .req_wdata0_i (req_wdata0_i),
      .req_wdata1_i (req_wdata1_i),
      .done_o       (done_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .psel_o       (psel_o),
      .penable_o    (penable_o),
      .pwrite_o     (pwrite_o),
      .paddr_o      (paddr_o),
      .pwdata_o     (pwdata_o),
      .pready_i     (pready_i),
      .pslverr_i    (pslverr_i),
      .prdata_i     (prdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      int          wait_n;
      logic        slverr;
      logic [31:0] srdata;
      logic [1:0]  exp_done;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_acc;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic        wr;
      logic [31:0] wdata;
   } setup_t;

   typedef struct {
      logic [1:0]  done;
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } rsp_t;

   setup_t sq[$];
   rsp_t   rq[$];
   vec_t   vecs[7];

   int checks   = 0;
   int failures = 0;

   int          cur_wait  = 0;
   logic        cur_err   = 1'b0;
   logic [31:0] cur_rdata = 32'h0;
   int          acc_cnt   = 0;
   int          acc_len   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // APB slave: ready after cur_wait wait states; drives junk when not ready
   initial begin
      pready_i  = 1'b0;
      pslverr_i = 1'b1;
      prdata_i  = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if (psel_o && penable_o) begin
            if (acc_cnt == cur_wait) begin
               pready_i  = 1'b1;
               pslverr_i = cur_err;
               prdata_i  = cur_rdata;
            end else begin
               pready_i  = 1'b0;
               pslverr_i = 1'b1;
               prdata_i  = 32'hBAD0BAD0;
            end
            acc_cnt++;
         end else begin
            acc_cnt   = 0;
            pready_i  = 1'b0;
            pslverr_i = 1'b1;
            prdata_i  = 32'hBAD0BAD0;
         end
      end
   end

   // Scoreboard monitor: pops expected SETUP and completion records
   initial begin
      setup_t s;
      rsp_t   r;
      forever begin
         @(negedge clk);
         if (psel_o && !penable_o) begin
            acc_len = 0;
            if (sq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_setup actual=%0h required=none", paddr_o);
            end else begin
               s = sq.pop_front();
               chk("setup_paddr", 64'(paddr_o), 64'(s.addr));
               chk("setup_pwrite", 64'(pwrite_o), 64'(s.wr));
               chk("setup_pwdata", 64'(pwdata_o), 64'(s.wdata));
            end
         end
         if (psel_o && penable_o) acc_len++;
         if (done_o != 2'b00) begin
            if (rq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=%0b required=00", done_o);
            end else begin
               r = rq.pop_front();
               chk("done", 64'(done_o), 64'(r.done));
               chk("rsp_rdata", 64'(rsp_rdata_o), 64'(r.rdata));
               chk("rsp_err", 64'(rsp_err_o), 64'(r.err));
               chk("access_cycles", 64'(acc_len), 64'(r.acc));
               chk("idle_at_done", 64'({psel_o, penable_o}), 64'(2'b00));
            end
         end
      end
   end

   task automatic wait_done(output logic [1:0] d, output int lat);
      lat = 0;
      d   = 2'b00;
      while (d == 2'b00 && lat < 200) begin
         @(negedge clk);
         lat++;
         d = done_o;
      end
      if (d == 2'b00) begin
         checks++;
         failures++;
         $display("FAIL done_wait_expired actual=none required=done");
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [1:0] d;
      int         lat;
      req_addr0_i  = v.addr;
      req_addr1_i  = v.addr;
      req_wdata0_i = v.wdata;
      req_wdata1_i = v.wdata;
      req_write_i  = {v.wr, v.wr};
      cur_wait     = v.wait_n;
      cur_err      = v.slverr;
      cur_rdata    = v.srdata;
      sq.push_back('{v.addr, v.wr, v.wr ? v.wdata : 32'h0});
      rq.push_back('{v.exp_done, v.exp_rdata, v.exp_err, v.exp_acc});
      req_i = v.req;
      wait_done(d, lat);
      chk("latency", 64'(lat), 64'(2 + v.exp_acc));
      req_i = req_i & ~d;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [1:0] d;
      int         lat;
      int         n;
      logic       g;
      vec_t       pre;

      //          req    wr    addr   wdata         wait slverr srdata        done   rdata         err  acc
      vecs[0] = '{2'b01, 1'b1, 5'd5,  32'hDEADBEEF, 0,   1'b0, 32'h0,        2'b01, 32'h0,        1'b0, 1};
      vecs[1] = '{2'b10, 1'b0, 5'd5,  32'h0,        3,   1'b0, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1'b0, 4};
      vecs[2] = '{2'b01, 1'b0, 5'd7,  32'h0,        4,   1'b0, 32'h77777777, 2'b01, 32'h0,        1'b1, 4};
      vecs[3] = '{2'b01, 1'b1, 5'd9,  32'h12345678, 1,   1'b0, 32'h0,        2'b01, 32'h0,        1'b0, 2};
      vecs[4] = '{2'b10, 1'b1, 5'd31, 32'hA5A5A5A5, 0,   1'b1, 32'h0,        2'b10, 32'h0,        1'b1, 1};
      vecs[5] = '{2'b01, 1'b0, 5'd0,  32'h0,        0,   1'b1, 32'hCAFEF00D, 2'b01, 32'hCAFEF00D, 1'b1, 1};
      vecs[6] = '{2'b10, 1'b0, 5'd31, 32'h0,        2,   1'b0, 32'h0F0F0F0F, 2'b10, 32'h0F0F0F0F, 1'b0, 3};

      resetn       = 1'b0;
      req_i        = 2'b00;
      req_write_i  = 2'b00;
      req_addr0_i  = 5'd0;
      req_addr1_i  = 5'd0;
      req_wdata0_i = 32'h0;
      req_wdata1_i = 32'h0;

      repeat (2) @(negedge clk);
      chk("reset_ctrl", 64'({psel_o, penable_o, pwrite_o, paddr_o, done_o, rsp_err_o}), 64'h0);
      chk("reset_data", {pwdata_o, rsp_rdata_o}, 64'h0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Contention: both requesters held from reset, grants must alternate
      resetn       = 1'b0;
      req_i        = 2'b11;
      req_write_i  = 2'b01;
      req_addr0_i  = 5'd1;
      req_addr1_i  = 5'd2;
      req_wdata0_i = 32'h11110000;
      req_wdata1_i = 32'h22220000;
      cur_wait     = 0;
      cur_err      = 1'b0;
      cur_rdata    = 32'h5A5A5A5A;
      for (int k = 0; k < 4; k++) begin
         g = k[0];
         sq.push_back('{g ? 5'd2 : 5'd1, ~g, g ? 32'h0 : 32'h11110000});
         rq.push_back('{g ? 2'b10 : 2'b01, g ? 32'h5A5A5A5A : 32'h0, 1'b0, 1});
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_done(d, lat);
         chk("contention_grant", 64'(d), 64'(k[0] ? 2'b10 : 2'b01));
         if (k == 3) begin
            req_i = 2'b00;
         end else begin
            @(negedge clk);
            chk("contention_setup_next", 64'({psel_o, penable_o}), 64'(2'b10));
         end
      end
      repeat (3) @(negedge clk);

      // Serve requester 0 so the pointer sits on requester 1 before the reset test
      pre = '{2'b01, 1'b1, 5'd4, 32'h00000004, 0, 1'b0, 32'h0, 2'b01, 32'h0, 1'b0, 1};
      run_vec(pre);

      // Reset during an ACCESS wait state drops the transfer
      req_addr1_i = 5'd6;
      req_write_i = 2'b00;
      cur_wait    = 255;
      sq.push_back('{5'd6, 1'b0, 32'h0});
      req_i = 2'b10;
      n = 0;
      while (!(psel_o && penable_o) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_access", 64'({psel_o, penable_o}), 64'(2'b11));
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("abort_ctrl_zero", 64'({psel_o, penable_o, done_o}), 64'h0);
      chk("abort_paddr_zero", 64'(paddr_o), 64'h0);
      @(negedge clk);
      req_i        = 2'b11;
      req_write_i  = 2'b01;
      req_addr0_i  = 5'd10;
      req_wdata0_i = 32'hABCD0123;
      cur_wait     = 0;
      cur_err      = 1'b0;
      sq.push_back('{5'd10, 1'b1, 32'hABCD0123});
      rq.push_back('{2'b01, 32'h0, 1'b0, 1});
      @(negedge clk);
      resetn = 1'b1;
      wait_done(d, lat);
      chk("post_reset_first_grant", 64'(d), 64'(2'b01));
      req_i = 2'b00;
      repeat (3) @(negedge clk);

      chk("setup_queue_drained", 64'(sq.size()), 64'h0);
      chk("rsp_queue_drained", 64'(rq.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
